// File: rtl/car_pkg.sv
// Shared encodings for the keypad PIN entry front end.
package car_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_SUBMIT,
    ST_UNLOCKED,
    ST_LOCKOUT
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;
  localparam int PIN_W = 16;
  localparam int TMR_W = 16;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/pin_entry_controller_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module cycle_timer
  import car_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pin_entry_controller.sv
// Keypad PIN entry: digit accumulation, submit to passcode check, attempt
// tracking with timed lockout, and PIN hold while unlocked.
//
// state       | meaning
// ST_IDLE     | buffer empty, waiting for first digit
// ST_ENTRY    | collecting digits, idle timeout running
// ST_SUBMIT   | one cycle presenting pin, key_ok sampled
// ST_UNLOCKED | PIN accepted and held until CLEAR
// ST_LOCKOUT  | too many failures, all keys ignored
module pin_entry_controller
  import car_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             key_ok,
  output logic [PIN_W-1:0] pin,
  output logic             pin_valid,
  output logic             unlocked,
  output logic             locked_out,
  output logic             error,
  output logic [2:0]       digit_count,
  output logic [1:0]       attempts_left
);

  localparam logic [2:0]       DIGITS_L  = 3'(DIGITS);
  localparam logic [1:0]       MAX_L     = 2'(MAX_ATTEMPTS);
  localparam logic [TMR_W-1:0] LO_LOAD   = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LOAD   = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [PIN_W-1:0] acc, acc_nxt, acc_step;
  logic [2:0]       count_nxt;
  logic [1:0]       attempts_nxt;
  logic             error_nxt;
  logic             to_load, to_done, lo_load, lo_done;

  // acc*10 + digit via shifts; wraps at 16 bits
  assign acc_step = (acc << 3) + (acc << 1) + {{(PIN_W-4){1'b0}}, key_code};

  cycle_timer u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (to_load),
    .en       (state == ST_ENTRY),
    .load_val (TO_LOAD),
    .done     (to_done)
  );

  cycle_timer u_lockout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lo_load),
    .en       (state == ST_LOCKOUT),
    .load_val (LO_LOAD),
    .done     (lo_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      acc           <= '0;
      digit_count   <= '0;
      attempts_left <= MAX_L;
      error         <= 1'b0;
    end else begin
      state         <= state_nxt;
      acc           <= acc_nxt;
      digit_count   <= count_nxt;
      attempts_left <= attempts_nxt;
      error         <= error_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    count_nxt    = digit_count;
    attempts_nxt = attempts_left;
    error_nxt    = 1'b0;
    to_load      = 1'b0;
    lo_load      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (key_valid && is_digit(key_code)) begin
          acc_nxt   = {{(PIN_W-4){1'b0}}, key_code};
          count_nxt = 3'd1;
          to_load   = 1'b1;
          state_nxt = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (key_valid) begin
          to_load = 1'b1;
          if (is_digit(key_code)) begin
            if (digit_count < DIGITS_L) begin
              acc_nxt   = acc_step;
              count_nxt = digit_count + 3'd1;
            end
          end else if (key_code == KEY_CLEAR) begin
            acc_nxt   = '0;
            count_nxt = '0;
            state_nxt = ST_IDLE;
          end else if (key_code == KEY_ENTER) begin
            if (digit_count == DIGITS_L) begin
              state_nxt = ST_SUBMIT;
            end else begin
              error_nxt = 1'b1;
              acc_nxt   = '0;
              count_nxt = '0;
              state_nxt = ST_IDLE;
            end
          end
        end else if (to_done) begin
          acc_nxt   = '0;
          count_nxt = '0;
          state_nxt = ST_IDLE;
        end
      end
      ST_SUBMIT: begin
        if (key_ok) begin
          attempts_nxt = MAX_L;
          state_nxt    = ST_UNLOCKED;
        end else begin
          error_nxt    = 1'b1;
          acc_nxt      = '0;
          count_nxt    = '0;
          attempts_nxt = attempts_left - 2'd1;
          if (attempts_left == 2'd1) begin
            lo_load   = 1'b1;
            state_nxt = ST_LOCKOUT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_UNLOCKED: begin
        if (key_valid && key_code == KEY_CLEAR) begin
          acc_nxt   = '0;
          count_nxt = '0;
          state_nxt = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (lo_done) begin
          attempts_nxt = MAX_L;
          state_nxt    = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign pin        = (state == ST_SUBMIT || state == ST_UNLOCKED) ? acc : '0;
  assign pin_valid  = (state == ST_SUBMIT);
  assign unlocked   = (state == ST_UNLOCKED);
  assign locked_out = (state == ST_LOCKOUT);

endmodule

// File: tb/tb_pin_entry_controller.sv
// Directed checks of the PIN entry controller with a 9999 passcode.
module tb_pin_entry_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        key_ok;
  logic [15:0] pin;
  logic        pin_valid, unlocked, locked_out, error;
  logic [2:0]  digit_count;
  logic [1:0]  attempts_left;

  int total = 0;
  int bad = 0;

  assign key_ok = (pin == 16'd9999);

  always #5 clk = ~clk;

  pin_entry_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .key_ok        (key_ok),
    .pin           (pin),
    .pin_valid     (pin_valid),
    .unlocked      (unlocked),
    .locked_out    (locked_out),
    .error         (error),
    .digit_count   (digit_count),
    .attempts_left (attempts_left)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Strobe one key; returns at the negedge after the sampling posedge.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    press(a); press(b); press(c); press(d); press(4'd11);
  endtask

  task automatic fail_once(input string tag, input logic [1:0] exp_left);
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    chk({tag, "_pv"}, pin_valid, 1);
    chk({tag, "_pin"}, pin, 1234);
    @(negedge clk);
    chk({tag, "_err"}, error, 1);
    chk({tag, "_left"}, attempts_left, exp_left);
  endtask

  initial begin
    int n;
    logic err_seen;

    repeat (2) @(negedge clk);
    chk("rst_pin", pin, 0);
    chk("rst_count", digit_count, 0);
    chk("rst_left", attempts_left, 3);
    chk("rst_flags", {pin_valid, unlocked, locked_out, error}, 0);
    rst_n = 1'b1;

    // 1: correct PIN
    enter4(4'd9, 4'd9, 4'd9, 4'd9);
    chk("t1_pv", pin_valid, 1);
    chk("t1_pin", pin, 9999);
    chk("t1_unl_early", unlocked, 0);
    @(negedge clk);
    chk("t1_unl", unlocked, 1);
    chk("t1_hold", pin, 9999);
    chk("t1_pv_off", pin_valid, 0);
    press(4'd5);
    press(4'd11);
    chk("t1_ign", {unlocked, pin_valid}, 2'b10);
    press(4'd10);
    chk("t1_relock", unlocked, 0);
    chk("t1_relock_pin", pin, 0);

    // 2: three failures then lockout
    fail_once("t2a", 2);
    fail_once("t2b", 1);
    fail_once("t2c", 0);
    chk("t2_lo", locked_out, 1);
    n = 0;
    while (locked_out && n < 1100) begin
      n++;
      key_valid = (n % 50 == 5);
      key_code  = (n % 100 == 5) ? 4'd11 : 4'd9;
      @(negedge clk);
    end
    key_valid = 1'b0;
    chk("t2_lo_len", n, 1000);
    chk("t2_left", attempts_left, 3);
    chk("t2_count", digit_count, 0);
    chk("t2_pin", pin, 0);

    // 3: short entry, then over-long entry
    press(4'd9); press(4'd9); press(4'd11);
    chk("t3_short_pv", pin_valid, 0);
    chk("t3_short_err", error, 1);
    chk("t3_short_left", attempts_left, 3);
    chk("t3_short_count", digit_count, 0);
    press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(4'd9);
    chk("t3_cnt_sat", digit_count, 4);
    press(4'd11);
    chk("t3_pv", pin_valid, 1);
    chk("t3_pin", pin, 9999);
    @(negedge clk);
    chk("t3_unl", unlocked, 1);
    press(4'd10);

    // 4: clear mid-entry, then unlock and relock
    press(4'd5);
    chk("t4_c1", digit_count, 1);
    press(4'd10);
    chk("t4_clr", digit_count, 0);
    chk("t4_clr_err", error, 0);
    enter4(4'd9, 4'd9, 4'd9, 4'd9);
    @(negedge clk);
    chk("t4_unl", unlocked, 1);
    press(4'd10);
    chk("t4_relock", {unlocked, pin}, 0);

    // 5: idle timeout
    press(4'd4); press(4'd2);
    chk("t5_c2", digit_count, 2);
    err_seen = 1'b0;
    repeat (4999) begin
      @(negedge clk);
      err_seen |= error;
    end
    chk("t5_before", digit_count, 2);
    @(negedge clk);
    err_seen |= error;
    chk("t5_after", digit_count, 0);
    chk("t5_noerr", err_seen, 0);
    chk("t5_left", attempts_left, 3);

    // 6: reset during lockout
    fail_once("t6a", 2);
    fail_once("t6b", 1);
    fail_once("t6c", 0);
    repeat (300) @(negedge clk);
    chk("t6_lo_mid", locked_out, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_lo_rst", locked_out, 0);
    chk("t6_left_rst", attempts_left, 3);
    @(negedge clk);
    rst_n = 1'b1;
    enter4(4'd9, 4'd9, 4'd9, 4'd9);
    chk("t6_pv", pin_valid, 1);
    @(negedge clk);
    chk("t6_unl", unlocked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
